// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decoded operands, specifiers and control for EX,
// with stall (hold), flush (bubble) and a saturating bubble counter.
module id_ex_pipe_reg #(
    parameter int DATA_W  = 16,
    parameter int REG_W   = 3,
    parameter int ALUOP_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               valid_id,
    input  logic [DATA_W-1:0]  pc2_id,
    input  logic [DATA_W-1:0]  rd1_id,
    input  logic [DATA_W-1:0]  rd2_id,
    input  logic [DATA_W-1:0]  imm_id,
    input  logic [REG_W-1:0]   rs_id,
    input  logic [REG_W-1:0]   rt_id,
    input  logic [REG_W-1:0]   rd_id,
    input  logic [ALUOP_W-1:0] aluop_id,
    input  logic [7:0]         ctrl_id,
    input  logic               I_format_id,
    input  logic               R_format_id,
    output logic               valid_ex,
    output logic [DATA_W-1:0]  pc2_ex,
    output logic [DATA_W-1:0]  rd1_ex,
    output logic [DATA_W-1:0]  rd2_ex,
    output logic [DATA_W-1:0]  imm_ex,
    output logic [REG_W-1:0]   RegisterRs_IDEX,
    output logic [REG_W-1:0]   RegisterRt_IDEX,
    output logic [REG_W-1:0]   RegisterRd_IDEX,
    output logic [ALUOP_W-1:0] aluop_ex,
    output logic               RegWrite_IDEX,
    output logic               MemRead_IDEX,
    output logic               MemWrite_IDEX,
    output logic               MemtoReg_IDEX,
    output logic               ALUSrc_IDEX,
    output logic               Branch_IDEX,
    output logic               Jump_IDEX,
    output logic               Halt_IDEX,
    output logic               I_format_ex,
    output logic               R_format_ex,
    output logic [15:0]        bubble_cnt
);

    logic [7:0] ctrlGated;
    logic [7:0] ctrlEx;
    logic       countBubble;

    // An invalid slot must never carry control, so nothing downstream can forward a write from it.
    assign ctrlGated   = valid_id ? ctrl_id : 8'h00;
    assign countBubble = flush | (~stall & ~valid_id);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_ex        <= 1'b0;
            pc2_ex          <= '0;
            rd1_ex          <= '0;
            rd2_ex          <= '0;
            imm_ex          <= '0;
            RegisterRs_IDEX <= '0;
            RegisterRt_IDEX <= '0;
            RegisterRd_IDEX <= '0;
            aluop_ex        <= '0;
            ctrlEx          <= 8'h00;
            I_format_ex     <= 1'b0;
            R_format_ex     <= 1'b0;
        end else if (flush) begin
            valid_ex        <= 1'b0;
            pc2_ex          <= '0;
            rd1_ex          <= '0;
            rd2_ex          <= '0;
            imm_ex          <= '0;
            RegisterRs_IDEX <= '0;
            RegisterRt_IDEX <= '0;
            RegisterRd_IDEX <= '0;
            aluop_ex        <= '0;
            ctrlEx          <= 8'h00;
            I_format_ex     <= 1'b0;
            R_format_ex     <= 1'b0;
        end else if (!stall) begin
            valid_ex        <= valid_id;
            pc2_ex          <= pc2_id;
            rd1_ex          <= rd1_id;
            rd2_ex          <= rd2_id;
            imm_ex          <= imm_id;
            RegisterRs_IDEX <= rs_id;
            RegisterRt_IDEX <= rt_id;
            RegisterRd_IDEX <= rd_id;
            aluop_ex        <= aluop_id;
            ctrlEx          <= ctrlGated;
            I_format_ex     <= I_format_id;
            R_format_ex     <= R_format_id;
        end
    end

    // Saturating count of bubbles entering EX; it pins at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= 16'h0000;
        end else if (countBubble && (bubble_cnt != 16'hFFFF)) begin
            bubble_cnt <= bubble_cnt + 16'd1;
        end
    end

    assign RegWrite_IDEX = ctrlEx[7];
    assign MemRead_IDEX  = ctrlEx[6];
    assign MemWrite_IDEX = ctrlEx[5];
    assign MemtoReg_IDEX = ctrlEx[4];
    assign ALUSrc_IDEX   = ctrlEx[3];
    assign Branch_IDEX   = ctrlEx[2];
    assign Jump_IDEX     = ctrlEx[1];
    assign Halt_IDEX     = ctrlEx[0];

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: stimulus pushes the expected EX slot,
// a monitor pops and compares one edge later.
`timescale 1ns/1ps
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic        valid;
        logic [15:0] pc2;
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic [15:0] imm;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [2:0]  rd;
        logic [4:0]  aluop;
        logic [7:0]  ctrl;
        logic        iFmt;
        logic        rFmt;
        logic [15:0] bubble;
    } slot_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, valid_id;
    logic [15:0] pc2_id, rd1_id, rd2_id, imm_id;
    logic [2:0]  rs_id, rt_id, rd_id;
    logic [4:0]  aluop_id;
    logic [7:0]  ctrl_id;
    logic        I_format_id, R_format_id;

    logic        valid_ex;
    logic [15:0] pc2_ex, rd1_ex, rd2_ex, imm_ex;
    logic [2:0]  RegisterRs_IDEX, RegisterRt_IDEX, RegisterRd_IDEX;
    logic [4:0]  aluop_ex;
    logic        RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX, MemtoReg_IDEX;
    logic        ALUSrc_IDEX, Branch_IDEX, Jump_IDEX, Halt_IDEX;
    logic        I_format_ex, R_format_ex;
    logic [15:0] bubble_cnt;

    int    vectors = 0;
    int    miscompares = 0;
    slot_t expQ[$];

    // Reference model: the slot EX should hold, plus an unbounded bubble tally.
    slot_t model;
    int    bubbles;

    id_ex_pipe_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_id(valid_id),
        .pc2_id(pc2_id), .rd1_id(rd1_id), .rd2_id(rd2_id), .imm_id(imm_id),
        .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id), .aluop_id(aluop_id),
        .ctrl_id(ctrl_id), .I_format_id(I_format_id), .R_format_id(R_format_id),
        .valid_ex(valid_ex), .pc2_ex(pc2_ex), .rd1_ex(rd1_ex), .rd2_ex(rd2_ex),
        .imm_ex(imm_ex), .RegisterRs_IDEX(RegisterRs_IDEX),
        .RegisterRt_IDEX(RegisterRt_IDEX), .RegisterRd_IDEX(RegisterRd_IDEX),
        .aluop_ex(aluop_ex), .RegWrite_IDEX(RegWrite_IDEX), .MemRead_IDEX(MemRead_IDEX),
        .MemWrite_IDEX(MemWrite_IDEX), .MemtoReg_IDEX(MemtoReg_IDEX),
        .ALUSrc_IDEX(ALUSrc_IDEX), .Branch_IDEX(Branch_IDEX), .Jump_IDEX(Jump_IDEX),
        .Halt_IDEX(Halt_IDEX), .I_format_ex(I_format_ex), .R_format_ex(R_format_ex),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic slot_t sampleDut();
        slot_t s;
        s = {valid_ex, pc2_ex, rd1_ex, rd2_ex, imm_ex, RegisterRs_IDEX, RegisterRt_IDEX,
             RegisterRd_IDEX, aluop_ex, RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX,
             MemtoReg_IDEX, ALUSrc_IDEX, Branch_IDEX, Jump_IDEX, Halt_IDEX,
             I_format_ex, R_format_ex, bubble_cnt};
        return s;
    endfunction

    function automatic logic [15:0] rnd16();
        logic [31:0] r;
        r = $urandom;
        return r[15:0];
    endfunction

    task automatic checkOutput(input string name, input slot_t expected);
        slot_t actual;
        actual = sampleDut();
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive one ID-stage instruction at the falling edge and record what EX must show after the next rising edge.
    task automatic applyStimulus(input logic st, input logic fl, input logic v,
                                 input logic [15:0] pc2, input logic [15:0] r1,
                                 input logic [15:0] r2, input logic [15:0] imm,
                                 input logic [2:0] rs, input logic [2:0] rt,
                                 input logic [2:0] rd, input logic [4:0] aluop,
                                 input logic [7:0] ctrl, input logic iF, input logic rF);
        @(negedge clk);
        stall = st; flush = fl; valid_id = v;
        pc2_id = pc2; rd1_id = r1; rd2_id = r2; imm_id = imm;
        rs_id = rs; rt_id = rt; rd_id = rd; aluop_id = aluop; ctrl_id = ctrl;
        I_format_id = iF; R_format_id = rF;
        if (fl) begin
            model = '0;
            bubbles++;
        end else if (!st) begin
            model.valid = v;
            model.pc2 = pc2; model.rd1 = r1; model.rd2 = r2; model.imm = imm;
            model.rs = rs; model.rt = rt; model.rd = rd; model.aluop = aluop;
            model.ctrl = v ? ctrl : 8'h00;
            model.iFmt = iF; model.rFmt = rF;
            if (!v) bubbles++;
        end
        model.bubble = (bubbles > 65535) ? 16'hFFFF : bubbles[15:0];
        expQ.push_back(model);
    endtask

    task automatic applyRandom(input logic st, input logic fl);
        logic [31:0] r;
        r = $urandom;
        applyStimulus(st, fl, r[0], rnd16(), rnd16(), rnd16(), rnd16(),
                      r[3:1], r[6:4], r[9:7], r[14:10], r[22:15], r[23], r[24]);
    endtask

    task automatic idle();
        @(negedge clk);
        stall = 1'b1;
        flush = 1'b0;
    endtask

    // Monitor: one registered EX slot appears per rising edge for each queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) checkOutput("scoreboard", expQ.pop_front());
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] r;
        model = '0;
        bubbles = 0;
        rst = 1'b1; stall = 1'b1; flush = 1'b0; valid_id = 1'b0;
        pc2_id = '0; rd1_id = '0; rd2_id = '0; imm_id = '0;
        rs_id = '0; rt_id = '0; rd_id = '0; aluop_id = '0; ctrl_id = '0;
        I_format_id = 1'b0; R_format_id = 1'b0;
        #2;
        checkOutput("reset state", '0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0102, 16'hAAAA, 16'h5555, 16'hFFF0,
                      3'd3, 3'd5, 3'd2, 5'd9, 8'h80, 1'b1, 1'b0);

        // Three held edges with the ID inputs changing underneath, then a fresh capture.
        applyRandom(1'b1, 1'b0);
        applyRandom(1'b1, 1'b0);
        applyRandom(1'b1, 1'b0);
        applyRandom(1'b0, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0200, 16'h1111, 16'h2222, 16'h0003,
                      3'd1, 3'd2, 3'd6, 5'd1, 8'h88, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0300, 16'h3333, 16'h4444, 16'h0005,
                      3'd4, 3'd4, 3'd4, 5'd2, 8'hFF, 1'b1, 1'b1);

        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0400, 16'h5555, 16'h6666, 16'h0007,
                      3'd0, 3'd1, 3'd7, 5'd3, 8'hFF, 1'b1, 1'b0);

        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            applyRandom(r[1:0] == 2'b00, r[4:2] == 3'b000);
        end

        // Asynchronous reset asserted between edges must clear everything before the next edge.
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0500, 16'h1234, 16'h0000, 16'h0000,
                      3'd1, 3'd2, 3'd3, 5'd4, 8'h80, 1'b0, 1'b1);
        idle();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset", '0);
        @(negedge clk);
        rst = 1'b0;
        model = '0;
        bubbles = 0;
        applyRandom(1'b0, 1'b0);

        for (int i = 0; i < 65537; i++) begin
            r = $urandom;
            applyRandom(r[0], 1'b1);
        end
        applyRandom(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0600, 16'h0001, 16'h0002, 16'h0003,
                      3'd1, 3'd2, 3'd3, 5'd5, 8'hFF, 1'b0, 1'b0);
        idle();
        @(negedge clk);

        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
ID/EX pipeline register of the 5-stage WISC pipeline, directly upstream of the forwarding unit and execute stage. It captures decoded operands, register specifiers and control from decode and presents them to EX. It supports stall (hold) and flush (bubble insertion) and tracks a valid bit. Its Rs/Rt/Rd, RegWrite and format outputs are the IDEX-side inputs of the forwarding unit.

Parameters:
DATA_W, 16, operand/immediate/PC width
REG_W, 3, register specifier width
ALUOP_W, 5, ALU opcode width

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-high reset
stall  in  1  hold all outputs this cycle (load-use hazard)
flush  in  1  replace the captured instruction with a bubble (branch/jump redirect)
valid_id  in  1  decode holds a real instruction
pc2_id  in  DATA_W  PC+2 of decode instruction
rd1_id, rd2_id  in  DATA_W  register file read data (Rs, Rt)
imm_id  in  DATA_W  sign/zero-extended immediate
rs_id, rt_id, rd_id  in  REG_W  source and destination specifiers
aluop_id  in  ALUOP_W  ALU operation
ctrl_id  in  8  {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, Jump, Halt}
I_format_id, R_format_id  in  1  instruction format flags
valid_ex  out  1  EX holds a real instruction
pc2_ex, rd1_ex, rd2_ex, imm_ex  out  DATA_W  registered copies
RegisterRs_IDEX, RegisterRt_IDEX, RegisterRd_IDEX  out  REG_W  registered specifiers
aluop_ex  out  ALUOP_W  registered ALU op
RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX, MemtoReg_IDEX, ALUSrc_IDEX, Branch_IDEX, Jump_IDEX, Halt_IDEX  out  1  registered control
I_format_ex, R_format_ex  out  1  registered format flags
bubble_cnt  out  16  number of bubbles inserted since reset (saturating)

Behaviour:
- Reset (async assert, any time): every output goes to 0 immediately, with no clock edge required. While rst=1, outputs stay 0. First capture occurs on the first rising edge after deassertion.
- Per rising edge, priority is rst > flush > stall > load:
  - flush=1: valid_ex=0; all control, format, aluop, specifier and data outputs = 0. Applies regardless of stall.
  - stall=1, flush=0: every output holds its value. bubble_cnt unchanged.
  - otherwise (load): all outputs take the *_id inputs; valid_ex=valid_id.
- Gating on invalid input: if a load captures valid_id=0, the control outputs (RegWrite..Halt) are forced 0. Data and specifier fields are still captured. This guarantees that no write is ever forwarded from an invalid slot.
- Latency: exactly 1 cycle from ID inputs to EX outputs. No combinational path from inputs to outputs.
- bubble_cnt: increments by 1 on each edge where flush=1, or where a load captures valid_id=0. Saturates at 16'hFFFF and never wraps. It is not affected by stall, and resets to 0.
- Halt_IDEX is captured like any other control bit. The block does not itself stop the pipeline.
- Stall and flush in the same cycle: the flush wins, and the held instruction is discarded.

Test Plan:
- Reset mid-run: load rd1_id=16'h1234, RegWrite=1, then assert rst between edges. All outputs go to 0 asynchronously, before the next edge, and bubble_cnt=0.
- Normal load: valid_id=1, rs_id=3, rt_id=5, rd_id=2, RegWrite=1, imm_id=16'hFFF0. Next edge gives RegisterRs_IDEX=3, RegisterRt_IDEX=5, RegisterRd_IDEX=2, RegWrite_IDEX=1, imm_ex=16'hFFF0, valid_ex=1.
- Stall for 3 cycles with the inputs changing every cycle. Outputs hold the pre-stall values for all 3 edges. On the first edge after stall drops, the current inputs are captured.
- Flush with stall=1 and RegWrite_IDEX=1 previously set. After the edge: valid_ex=0, RegWrite_IDEX=0, RegisterRd_IDEX=0, bubble_cnt incremented by 1.
- Invalid capture: valid_id=0, ctrl_id=8'hFF, rd_id=7. After the edge: all control outputs 0, RegisterRd_IDEX=7, valid_ex=0, bubble_cnt+1.
- Saturation: drive 65537 consecutive flush cycles. bubble_cnt stops at 16'hFFFF and never reads 0.
